// File: rtl/hilo_mul_unit.sv
// HI/LO register owner with an iterative shift-add MULT/MULTU engine and EX stall.
// Define FAST_MUL_EN to replace the iterative engine with a single-cycle multiply.
module hilo_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             flush,
    input  logic [2:0]       alucontrol,
    input  logic             hassign,
    input  logic [1:0]       hilo_en,
    input  logic [1:0]       hilo_mf,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall,
    output logic [WIDTH-1:0] hilo_out,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   hi, lo;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand, prod, result;
    logic [WIDTH-1:0]   mplier, mag_a, mag_b;
    logic               neg, is_mul, start, mt_ok;

    assign is_mul = (alucontrol == 3'b100);
    assign start  = valid & ~flush & is_mul & (hilo_en == 2'b11) & (state == IDLE);
    assign mt_ok  = valid & ~flush & ~stall & ~is_mul;

    // Magnitudes for sign-magnitude multiply; the most negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    assign mag_a  = (hassign & srca[WIDTH-1]) ? -srca : srca;
    assign mag_b  = (hassign & srcb[WIDTH-1]) ? -srcb : srcb;
    assign result = neg ? -prod : prod;

`ifdef FAST_MUL_EN
    logic signed [2*WIDTH-1:0] sprod;
    logic        [2*WIDTH-1:0] uprod;
    assign sprod = $signed({{WIDTH{srca[WIDTH-1]}}, srca}) * $signed({{WIDTH{srcb[WIDTH-1]}}, srcb});
    assign uprod = {{WIDTH{1'b0}}, srca} * {{WIDTH{1'b0}}, srcb};
`endif

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
`ifdef FAST_MUL_EN
        state_nxt = IDLE;
`else
        case (state)
            IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (flush)                         state_nxt = IDLE;
                else if (cnt == CW'(WIDTH - 1))    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            neg    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mt_ok) begin
                if (hilo_en == 2'b01)      hi <= srca;
                else if (hilo_en == 2'b00) lo <= srca;
            end
`ifdef FAST_MUL_EN
            if (start) {hi, lo} <= hassign ? sprod : uprod;
`else
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        neg    <= hassign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        prod   <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // DONE is the multiply's own last EX cycle; a kill here drops the result.
                    if (!flush) {hi, lo} <= result;
                end
                default: ;
            endcase
`endif
        end
    end

    always_comb begin
        hilo_out = '0;
        case (hilo_mf)
            2'b01:   hilo_out = hi;
            2'b00:   hilo_out = lo;
            default: hilo_out = '0;
        endcase
    end

    assign hi_o = hi;
    assign lo_o = lo;
endmodule

// File: tb/tb_hilo_mul_unit.sv
// Directed bench for hilo_mul_unit: vector table of MULT/MULTU/MTHI/MTLO rows plus
// hand sequences for flush, reset and DONE-cycle corner cases.
module tb_hilo_mul_unit;
    logic        clk = 1'b0;
    logic        rst, valid, flush, hassign;
    logic [2:0]  alucontrol;
    logic [1:0]  hilo_en, hilo_mf;
    logic [31:0] srca, srcb;
    logic        stall;
    logic [31:0] hilo_out, hi_o, lo_o;

    int total = 0;
    int bad   = 0;

`ifdef FAST_MUL_EN
    localparam int MS = 0;
`else
    localparam int MS = 33;
`endif

    always #5 clk = ~clk;

    hilo_mul_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid(valid), .flush(flush),
        .alucontrol(alucontrol), .hassign(hassign), .hilo_en(hilo_en), .hilo_mf(hilo_mf),
        .srca(srca), .srcb(srcb), .stall(stall), .hilo_out(hilo_out), .hi_o(hi_o), .lo_o(lo_o)
    );

    typedef struct {
        logic [2:0]  alu;
        logic [1:0]  en;
        logic        hs;
        logic [31:0] a, b, ehi, elo;
        int          est;
    } row_t;

    row_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        valid = 1'b0; flush = 1'b0; alucontrol = 3'b000; hassign = 1'b0;
        hilo_en = 2'b10; hilo_mf = 2'b10; srca = '0; srcb = '0;
    endtask

    task automatic drive_mul(input logic hs, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; alucontrol = 3'b100; hilo_en = 2'b11; hassign = hs; srca = a; srcb = b;
    endtask

    // Hold the instruction in EX while stalled, then let it retire and check the results.
    task automatic run_row(input row_t r, input string tag);
        int n;
        @(negedge clk);
        valid = 1'b1; alucontrol = r.alu; hilo_en = r.en; hassign = r.hs; srca = r.a; srcb = r.b;
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        set_idle();
        #1;
        chk({tag, "_stall_cycles"}, 32'(n), 32'(r.est));
        chk({tag, "_hi"}, hi_o, r.ehi);
        chk({tag, "_lo"}, lo_o, r.elo);
        hilo_mf = 2'b01; #1;
        chk({tag, "_mfhi"}, hilo_out, r.ehi);
        hilo_mf = 2'b00; #1;
        chk({tag, "_mflo"}, hilo_out, r.elo);
        hilo_mf = 2'b11; #1;
        chk({tag, "_mfnone"}, hilo_out, 32'h0);
        hilo_mf = 2'b10;
    endtask

    initial begin
        row_t r57;
        int   n;

        tbl[0]  = '{3'b100, 2'b11, 1'b1, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, MS};
        tbl[1]  = '{3'b100, 2'b11, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MS};
        tbl[2]  = '{3'b100, 2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, MS};
        tbl[3]  = '{3'b000, 2'b01, 1'b0, 32'h12345678, 32'h0,        32'h12345678, 32'h80000000, 0};
        tbl[4]  = '{3'b000, 2'b00, 1'b0, 32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE, 0};
        tbl[5]  = '{3'b100, 2'b10, 1'b1, 32'd5,        32'd7,        32'h12345678, 32'hCAFEBABE, 0};
        tbl[6]  = '{3'b010, 2'b11, 1'b1, 32'd5,        32'd7,        32'h12345678, 32'hCAFEBABE, 0};
        tbl[7]  = '{3'b100, 2'b11, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MS};
        tbl[8]  = '{3'b100, 2'b11, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MS};
        tbl[9]  = '{3'b100, 2'b11, 1'b1, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA988, MS};
        tbl[10] = '{3'b100, 2'b11, 1'b0, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, MS};
        tbl[11] = '{3'b100, 2'b11, 1'b1, 32'd5,        32'd7,        32'h00000000, 32'h00000023, MS};
        tbl[12] = '{3'b111, 2'b01, 1'b0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h00000023, 0};
        tbl[13] = '{3'b100, 2'b11, 1'b0, 32'd3,        32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFA, MS};
        r57     = tbl[11];

        set_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hilo_mf = 2'b00;
        #1;
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_hi", hi_o, 32'h0);
        chk("reset_lo", lo_o, 32'h0);
        chk("reset_hilo_out", hilo_out, 32'h0);
        hilo_mf = 2'b10;

        for (int i = 0; i < 14; i++) run_row(tbl[i], $sformatf("row%0d", i));

`ifndef FAST_MUL_EN
        // Flush in the 10th BUSY cycle: abort, no HI/LO change.
        @(negedge clk);
        drive_mul(1'b1, 32'd5, 32'd7);
        #1;
        chk("fbusy_start_stall", {31'b0, stall}, 32'h1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fbusy_flush_stall", {31'b0, stall}, 32'h1);
        @(negedge clk);
        set_idle();
        #1;
        chk("fbusy_after_stall", {31'b0, stall}, 32'h0);
        chk("fbusy_hi", hi_o, 32'h00000002);
        chk("fbusy_lo", lo_o, 32'hFFFFFFFA);
        run_row(r57, "fbusy_rerun");

        // Flush in the start cycle beats start.
        @(negedge clk);
        drive_mul(1'b0, 32'd9, 32'd9);
        flush = 1'b1;
        #1;
        chk("fstart_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        set_idle();
        #1;
        chk("fstart_stall_next", {31'b0, stall}, 32'h0);
        chk("fstart_lo", lo_o, 32'h00000023);

        // Reset mid-BUSY.
        @(negedge clk);
        drive_mul(1'b1, 32'd3, 32'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        #1;
        chk("rbusy_stall", {31'b0, stall}, 32'h0);
        chk("rbusy_hi", hi_o, 32'h0);
        chk("rbusy_lo", lo_o, 32'h0);

        // Flush in DONE drops the result; the FSM still returns to IDLE.
        @(negedge clk);
        drive_mul(1'b0, 32'd3, 32'd7);
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("fdone_stall_cycles", 32'(n), 32'd33);
        flush = 1'b1;
        @(negedge clk);
        set_idle();
        #1;
        chk("fdone_hi", hi_o, 32'h0);
        chk("fdone_lo", lo_o, 32'h0);
        run_row(r57, "fdone_rerun");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/hilo_mul_unit.md
Name: hilo_mul_unit

Overview:
- Execute-stage consumer of the ALU decoder's multiply/HI-LO controls (alucontrol, hassign, hilo_en, hilo_mf).
- Owns the HI and LO architectural registers and runs MULT/MULTU as an iterative shift-add multiplier.
- Asserts a pipeline stall while a multiply is in flight.
- Handles MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand and HI/LO width. Counter width is clog2(WIDTH). Only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- valid  input  1  an EX-stage instruction is present and not a bubble
- flush  input  1  the EX-stage instruction is killed; aborts an in-flight multiply
- alucontrol  input  3  3'b100 = multiply; all other values are ignored here
- hassign  input  1  1 = signed multiply (MULT), 0 = unsigned (MULTU)
- hilo_en  input  2  10 = no write, 11 = write HI and LO, 01 = write HI, 00 = write LO
- hilo_mf  input  2  01 = read HI, 00 = read LO, others = no read
- srca  input  WIDTH  rs operand (multiplicand; MTHI/MTLO data)
- srcb  input  WIDTH  rt operand (multiplier)
- stall  output  1  freeze IF/ID/EX; combinational
- hilo_out  output  WIDTH  MFHI/MFLO result; combinational
- hi_o  output  WIDTH  current HI register
- lo_o  output  WIDTH  current LO register

Behaviour:
- Reset (clk edge with rst=1): HI=0, LO=0, state=IDLE, counter=0, internal accumulators=0. stall=0, hilo_out=0.
- start = valid & ~flush & alucontrol==3'b100 & hilo_en==2'b11 & state==IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE, on start:
  - Latch operand magnitudes |srca| and |srcb|. Two's-complement negate only when hassign=1 and the operand MSB is 1. 0x80000000 keeps magnitude 0x80000000.
  - Latch neg = hassign & (srca[31] ^ srcb[31]).
  - Clear the 2*WIDTH product, set counter=0, go to BUSY.
  - stall=1 combinationally in this cycle.
- BUSY:
  - Each cycle: if the multiplier LSB is 1, add the shifted multiplicand to the product; shift the multiplicand left and the multiplier right; counter++.
  - When counter==WIDTH-1 at the edge, go to DONE.
  - stall=1 throughout.
  - flush=1 aborts: next state IDLE, HI/LO unchanged.
- DONE:
  - stall=0.
  - At the edge: {HI,LO} <= neg ? -product : product. Go to IDLE.
  - No new start is accepted in DONE.
- Timing: stall is high for exactly WIDTH+1 consecutive cycles (start cycle plus WIDTH BUSY cycles). HI/LO update at the end of the DONE cycle, the same edge at which the instruction leaves EX.
- MTHI/MTLO: when valid & ~flush & ~stall & alucontrol!=3'b100:
  - hilo_en==01 gives HI<=srca.
  - hilo_en==00 gives LO<=srca.
- hilo_en==10: never writes. hilo_en==11 with alucontrol!=100: no write.
- hilo_out: hilo_mf==01 gives HI; 00 gives LO; else 0. Reads the registered value, with no bypass of a same-edge write. The following instruction sees the update.
- Simultaneous events:
  - rst dominates everything.
  - flush dominates start.
  - flush in DONE suppresses the HI/LO write.
  - During BUSY, MTHI/MTLO and start are blocked by stall.
- hi_o/lo_o always reflect the registers.

Optional Feature:
- FAST_MUL_EN defined:
  - Single-cycle multiply using the signed/unsigned * operator chosen by hassign.
  - HI/LO are written at the end of the start cycle; stall is tied 0; the FSM stays in IDLE.
  - flush and valid gating are unchanged.
- Undefined: the iterative FSM described above.

Test Plan:
- MULT srca=3, srcb=0xFFFFFFFE, hassign=1 -> stall high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT 0x80000000 × 0xFFFFFFFF -> HI=0x00000000, LO=0x80000000.
- MTHI srca=0x12345678, then MFHI -> hilo_out=0x12345678, LO unchanged. MTLO 0xCAFEBABE then MFLO -> 0xCAFEBABE.
- MULT 5×7 with flush asserted in the 10th BUSY cycle -> stall low on the next cycle, HI/LO keep prior values, and the next MULT runs a full 33-cycle stall.
- rst pulsed mid-BUSY -> next cycle stall=0, HI=LO=0, state IDLE.
- hilo_en=10 with alucontrol=100, and hilo_en=11 with alucontrol=010 -> no stall, HI/LO unchanged. With FAST_MUL_EN: MULT 3×-2 -> stall never asserted, HI/LO correct after 1 cycle.
